// File: rtl/asrv32_fetch_pkg.sv
// Shared types for the ASRV32 fetch stage: state encoding and PC helpers.
// Fetch states keep the same 2-bit encodings used elsewhere in the core.
package asrv32_fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/asrv32_fetch_if.sv
// Fetch-stage bus: PC update from writeback, decode handshake, imem req/ack.
// master = fetch stage, slave = surrounding pipeline and instruction memory.
interface asrv32_fetch_if;
  import asrv32_fetch_pkg::*;

  logic            pc_update;
  logic [XLEN-1:0] new_pc;
  logic            ready;
  logic            valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            misaligned;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_data;

  modport master (
    input  pc_update, new_pc, ready, imem_ack, imem_data,
    output valid, inst, pc, misaligned, imem_req, imem_addr
  );

  modport slave (
    output pc_update, new_pc, ready, imem_ack, imem_data,
    input  valid, inst, pc, misaligned, imem_req, imem_addr
  );

endinterface

// File: rtl/asrv32_fetch.sv
// Instruction fetch: launches one imem read per committed PC, holds the word
// for decode, discards stale returns and reports misaligned targets without fetching.
module asrv32_fetch
  import asrv32_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  asrv32_fetch_if.master  bus
);

  fetch_state_t    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;

  logic            launch;
  logic [XLEN-1:0] launch_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= FETCH_REQ;
      req_q        <= 1'b1;
      addr_q       <= {PC_RESET[31:2], 2'b00};
      valid_q      <= 1'b0;
      inst_q       <= '0;
      pc_q         <= PC_RESET;
      mis_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      mis_q        <= mis_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    mis_d        = mis_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    launch       = 1'b0;
    launch_pc    = bus.new_pc;

    case (state_q)
      FETCH_IDLE: begin
        if (bus.pc_update) launch = 1'b1;
      end
      FETCH_REQ: begin
        if (!req_q) begin
          // One-cycle gap after a stale return: relaunch the newest target.
          launch       = 1'b1;
          launch_pc    = bus.pc_update ? bus.new_pc : pend_pc_q;
          pend_valid_d = 1'b0;
        end else if (bus.imem_ack) begin
          if (pend_valid_q || bus.pc_update) begin
            req_d        = 1'b0;
            pend_valid_d = 1'b0;
            if (bus.pc_update) pend_pc_d = bus.new_pc;
          end else begin
            req_d   = 1'b0;
            valid_d = 1'b1;
            inst_d  = bus.imem_data;
            pc_d    = addr_q;
            mis_d   = 1'b0;
            state_d = FETCH_HOLD;
          end
        end else if (bus.pc_update) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = bus.new_pc;
        end
      end
      FETCH_HOLD: begin
        // A flush outranks a same-cycle accept.
        if (bus.pc_update) begin
          launch = 1'b1;
        end else if (bus.ready) begin
          valid_d = 1'b0;
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (launch) begin
      if (pc_misaligned(launch_pc)) begin
        state_d = FETCH_HOLD;
        req_d   = 1'b0;
        valid_d = 1'b1;
        mis_d   = 1'b1;
        pc_d    = launch_pc;
        inst_d  = '0;
      end else begin
        state_d = FETCH_REQ;
        req_d   = 1'b1;
        addr_d  = {launch_pc[31:2], 2'b00};
        valid_d = 1'b0;
      end
    end
  end

  assign bus.valid      = valid_q;
  assign bus.inst       = inst_q;
  assign bus.pc         = pc_q;
  assign bus.misaligned = mis_q;
  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;

endmodule

// File: tb/tb_asrv32_fetch.sv
// Randomized bench for asrv32_fetch: a scoreboard of expected presentations
// built from issued target PCs (last update wins), plus imem protocol checks.
module tb_asrv32_fetch;

  localparam logic [31:0] PC_RST = 32'h100;

  logic clk = 1'b0;
  logic rst;

  asrv32_fetch_if bus();

  asrv32_fetch #(.PC_RESET(PC_RST)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passes = 0;
  int   force_lat = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic exp_t expect_for(input logic [31:0] t);
    exp_t e;
    e.pc   = t;
    e.mis  = (t[1:0] != 2'b00);
    e.inst = e.mis ? 32'h0 : mem_word(t);
    return e;
  endfunction

  function automatic logic [31:0] rand_target(input bit mis);
    logic [31:0] t;
    t = $urandom & 32'h0000_FFFC;
    if (mis) t = t | $urandom_range(1, 3);
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction memory: variable latency per request, data derived from address.
  int cnt = 0;
  bit busy = 1'b0;
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.imem_ack  = 1'b0;
      bus.imem_data = $urandom;
      if (rst) begin
        busy = 1'b0;
      end else if (bus.imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
          force_lat = -1;
        end
        if (cnt == 0) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = mem_word(bus.imem_addr);
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: protocol/stability checks and scoreboard pops on each new presentation.
  logic        pv = 0, pr = 0, pu = 0, prst = 1, preq = 0, pack = 0, pmis = 0;
  logic [31:0] paddr = 0, ppc = 0, pinst = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.imem_req) chk("req_addr_aligned", {30'h0, bus.imem_addr[1:0]}, 32'h0);
        if (!prst) begin
          if (preq && !pack) begin
            chk("req_held", bus.imem_req, 1);
            chk("addr_held", bus.imem_addr, paddr);
          end
          if (preq && pack) chk("req_drop_after_ack", bus.imem_req, 0);
          if (pv && !pr && !pu) begin
            chk("hold_valid", bus.valid, 1);
            chk("hold_pc", bus.pc, ppc);
            chk("hold_inst", bus.inst, pinst);
            chk("hold_mis", bus.misaligned, pmis);
          end
        end
        if (bus.valid && (!pv || pr || pu || prst)) begin
          if (expq.size() == 0) begin
            checks++;
            $display("FAIL unexpected_presentation: got pc %h, expected none", bus.pc);
          end else begin
            e = expq.pop_front();
            chk("out_pc", bus.pc, e.pc);
            chk("out_inst", bus.inst, e.inst);
            chk("out_mis", bus.misaligned, e.mis);
          end
        end
      end
      pv    = bus.valid;
      pr    = bus.ready;
      pu    = bus.pc_update;
      prst  = rst;
      preq  = bus.imem_req;
      pack  = bus.imem_ack;
      paddr = bus.imem_addr;
      ppc   = bus.pc;
      pinst = bus.inst;
      pmis  = bus.misaligned;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] t);
    bus.pc_update = 1'b1;
    bus.new_pc    = t;
    tick();
    bus.pc_update = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.valid && n < 100) begin
      tick();
      n++;
    end
    if (!bus.valid) begin
      checks++;
      $display("FAIL wait_valid: got no valid, expected valid within 100 cycles");
    end
  endtask

  task automatic accept(input int hold);
    repeat (hold) tick();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    chk("valid_after_accept", bus.valid, 0);
    chk("no_req_in_idle", bus.imem_req, 0);
  endtask

  initial begin
    logic [31:0] t, t2;
    int          kind, lat;
    bus.pc_update = 1'b0;
    bus.new_pc    = 32'h0;
    bus.ready     = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", bus.valid, 0);
    chk("rst_req", bus.imem_req, 1);
    chk("rst_addr", bus.imem_addr, PC_RST);
    chk("rst_pc", bus.pc, PC_RST);
    chk("rst_inst", bus.inst, 0);
    chk("rst_mis", bus.misaligned, 0);
    expq.push_back(expect_for(PC_RST));
    rst = 1'b0;
    wait_valid();
    accept(5);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          t = rand_target($urandom_range(0, 3) == 0);
          expq.push_back(expect_for(t));
          issue(t);
          wait_valid();
          accept($urandom_range(0, 4));
        end
        1: begin
          // Overwrite an outstanding fetch, possibly in the ack cycle itself.
          lat = $urandom_range(2, 4);
          t = rand_target(1'b0);
          force_lat = lat;
          issue(t);
          repeat ($urandom_range(0, lat)) tick();
          t2 = rand_target($urandom_range(0, 3) == 0);
          expq.push_back(expect_for(t2));
          issue(t2);
          wait_valid();
          accept($urandom_range(0, 4));
        end
        2: begin
          // Flush while an instruction is held, sometimes with ready also high.
          t = rand_target($urandom_range(0, 3) == 0);
          expq.push_back(expect_for(t));
          issue(t);
          wait_valid();
          repeat ($urandom_range(0, 3)) tick();
          t2 = rand_target($urandom_range(0, 3) == 0);
          expq.push_back(expect_for(t2));
          bus.ready = ($urandom_range(0, 1) == 1);
          issue(t2);
          bus.ready = 1'b0;
          wait_valid();
          accept($urandom_range(0, 4));
        end
        default: begin
          // Reset mid-fetch: the outstanding target is dropped, PC_RESET refetched.
          t = rand_target(1'b0);
          force_lat = 6;
          issue(t);
          repeat ($urandom_range(0, 2)) tick();
          rst = 1'b1;
          expq.push_back(expect_for(PC_RST));
          tick();
          rst = 1'b0;
          chk("midrst_valid", bus.valid, 0);
          chk("midrst_req", bus.imem_req, 1);
          chk("midrst_addr", bus.imem_addr, PC_RST);
          wait_valid();
          accept($urandom_range(0, 4));
        end
      endcase
    end

    repeat (5) tick();
    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
